hazard_stall_unit: RTL
======================

Name: hazard_stall_unit

Overview:
Parametrised load/RAW hazard detector for the in-order pipeline, successor to the fixed 3-bit, 2-read-port, 2-producer-stage stall logic. Sits in decode and compares the IF/ID source registers against destination registers held in NSTG downstream producer stages. It drives a single stall to the PC/IFID enables and a bubble into ID/EX. A down-counter replaces the chained flops for bubble timing, and an optional forwarding mode stalls only on load-use.

Parameters:
AW, 3, register address width
NRD, 2, number of source read ports checked
NSTG, 2, producer stages checked; index 0 = ID/EX (nearest), NSTG-1 = furthest before writeback
FWD, 0, 0 = no forwarding (stall on any RAW); 1 = forwarding present (stall only on load-use)
ZERO_REG, 0, 1 = address 0 is hardwired zero and never creates a hazard
CW, $clog2(NSTG+2), stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rd_addr  in  NRD*AW  IF/ID source addresses, port i at [i*AW +: AW]
rd_valid  in  NRD  port i actually reads a register
wr_addr  in  NSTG*AW  destination address per producer stage, stage k at [k*AW +: AW]
wr_en  in  NSTG  stage k will write its destination
wr_is_load  in  NSTG  stage k holds a memory load
flush  in  1  branch/exception flush; kills the pending stall
stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
stall_cnt  out  CW  remaining registered stall cycles after the current one
hazard_stage  out  CW  nearest stage index causing the current detection; NSTG when no detection

Behaviour:
- Reset (rst=0, async): cnt=0, so stall=0, stall_cnt=0, hazard_stage=NSTG. Registers release on the first clk edge after rst rises.
- match[k][i] = rd_valid[i] & wr_en[k] & (rd_addr_i == wr_addr_k) & ~(ZERO_REG & rd_addr_i==0).
- FWD=0: stage k qualifies if any match[k][i]. Required cycles need_k = NSTG+1-k. With NSTG=2 this gives 3 cycles for ID/EX and 2 for EX/MEM, matching the previous generation.
- FWD=1: only k=0 with wr_is_load[0] qualifies, need_0 = 1. All other matches are resolved by forwarding.
- det = any qualifying stage. need = need of the lowest qualifying k (nearest stage dominates). hazard_stage = that k.
- Combinational output: stall = ~flush & (det | cnt!=0). stall_cnt = cnt.
- Counter, registered:
  - flush: cnt <= 0.
  - otherwise: cnt <= max(cnt - (cnt!=0), det ? need-1 : 0).
  - The max means a new, longer hazard seen during a stall extends it and never shortens it.
- Latency: stall rises in the same cycle the hazard appears in decode, with no registered delay. It stays high for exactly need cycles when no further hazards occur.
- During a stall, producer inputs see bubbles (wr_en=0) advancing. Re-detection of the same hazard in a later stage yields a need no larger than the remaining cnt, so the total is unchanged.
- Simultaneous flush and det: flush wins, stall=0, cnt=0.
- rst asserted mid-stall: cnt clears immediately and stall drops asynchronously.
- Counter saturates at NSTG. No wrap is possible because need-1 <= NSTG.

Decomposition:
- Shared package hazard_pkg: function clog2, localparam NO_HAZARD = NSTG encoding, and the need-cycles function need(k,NSTG,FWD).
- One sub-module is natural: hazard_cmp, which performs the NRD x AW comparison for one producer stage and outputs a 1-bit hit. Instantiate it NSTG times via generate.
- Priority encode and counter stay in the top module.

Test Plan:
- Default params, reset, then rd_addr port0=3, rd_valid=01, wr_addr[0]=3, wr_en=01 for one cycle, then bubbles -> stall high exactly 3 cycles; stall_cnt 0,2,1 then 0; hazard_stage 0 in cycle 1.
- Default, match only in stage 1 (wr_addr[1]=5 = rd port1) -> stall 2 cycles; hazard_stage=1.
- Default, stage 1 hazard in cycle 0, then a stage 0 hazard appears in cycle 1 -> cnt goes 1 then 2; stall lasts 4 cycles total.
- FWD=1: stage 0 match with wr_is_load[0]=1 -> 1-cycle stall, stall_cnt stays 0. Same match with wr_is_load=0, or a stage 1 match -> no stall.
- ZERO_REG=1, rd_addr=0 matching wr_addr[0]=0 with wr_en=1 -> no stall. With ZERO_REG=0 -> 3-cycle stall.
- Stage 0 hazard, flush asserted in the 2nd stall cycle -> stall 0 that cycle and after, cnt=0. Separately, rst low mid-stall -> stall drops without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared helpers for the decode-stage hazard/stall unit: width helper,
// the "no hazard" stage encoding and the stall-length rule per producer stage.
package hazard_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // The stage index one past the furthest producer means "nothing detected".
  function automatic int no_hazard(input int nstg);
    return nstg;
  endfunction

  // Without forwarding a result reaches the register file nstg+1-k cycles later;
  // with forwarding only a load in the nearest stage costs a single bubble.
  function automatic int need(input int k, input int nstg, input int fwd);
    if (fwd != 0) return (k == 0) ? 1 : 0;
    return nstg + 1 - k;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Decode-side bus of the hazard unit: source/producer descriptors in,
// stall decision and diagnostic state out.
interface hazard_stall_unit_if
  import hazard_pkg::*;
#(
  parameter int AW   = 3,
  parameter int NRD  = 2,
  parameter int NSTG = 2,
  parameter int CW   = clog2(NSTG + 2)
);
  logic [NRD*AW-1:0]  rd_addr;
  logic [NRD-1:0]     rd_valid;
  logic [NSTG*AW-1:0] wr_addr;
  logic [NSTG-1:0]    wr_en;
  logic [NSTG-1:0]    wr_is_load;
  logic               flush;
  logic               stall;
  logic [CW-1:0]      stall_cnt;
  logic [CW-1:0]      hazard_stage;

  modport master (
    output rd_addr, rd_valid, wr_addr, wr_en, wr_is_load, flush,
    input  stall, stall_cnt, hazard_stage
  );

  modport slave (
    input  rd_addr, rd_valid, wr_addr, wr_en, wr_is_load, flush,
    output stall, stall_cnt, hazard_stage
  );
endinterface

// File: rtl/hazard_stall_unit_cmp.sv
// Compares every IF/ID source port against one producer stage's destination.
module hazard_cmp #(
  parameter int AW       = 3,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 0
) (
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic [NRD-1:0]    rd_valid,
  input  logic [AW-1:0]     wr_addr,
  input  logic              wr_en,
  output logic              hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      // A hardwired zero register never carries a real dependency.
      if (rd_valid[i] && wr_en && (rd_addr[i*AW +: AW] == wr_addr) &&
          !((ZERO_REG != 0) && (rd_addr[i*AW +: AW] == '0)))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-stage RAW/load-use hazard detector: immediate stall on detection,
// then a down-counter holds the stall for the remaining required cycles.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int AW       = 3,
  parameter int NRD      = 2,
  parameter int NSTG     = 2,
  parameter int FWD      = 0,
  parameter int ZERO_REG = 0,
  parameter int CW       = clog2(NSTG + 2)
) (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_unit_if.slave  bus
);

  logic [NSTG-1:0] hit;
  logic [NSTG-1:0] qual;
  logic            det;
  logic [CW-1:0]   need_m1;
  logic [CW-1:0]   hazard_stage;
  logic [CW-1:0]   cnt_dec;
  logic [CW-1:0]   cnt_d;
  logic [CW-1:0]   cnt_q;

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    hazard_cmp #(
      .AW       (AW),
      .NRD      (NRD),
      .ZERO_REG (ZERO_REG)
    ) u_cmp (
      .rd_addr  (bus.rd_addr),
      .rd_valid (bus.rd_valid),
      .wr_addr  (bus.wr_addr[k*AW +: AW]),
      .wr_en    (bus.wr_en[k]),
      .hit      (hit[k])
    );

    // With forwarding only a load sitting in the nearest stage cannot be bypassed.
    if (FWD == 0) begin : g_nofwd
      assign qual[k] = hit[k];
    end else if (k == 0) begin : g_load
      assign qual[k] = hit[k] & bus.wr_is_load[k];
    end else begin : g_fwd
      assign qual[k] = 1'b0 & hit[k] & bus.wr_is_load[k];
    end
  end

  always_comb begin
    det          = |qual;
    hazard_stage = CW'(no_hazard(NSTG));
    need_m1      = '0;
    // Scan furthest to nearest so the nearest qualifying stage wins.
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (qual[k]) begin
        hazard_stage = CW'(k);
        need_m1      = CW'(need(k, NSTG, FWD) - 1);
      end
    end
  end

  // Taking the max lets a longer new hazard extend a stall but never shorten it.
  always_comb begin
    cnt_dec = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    if (bus.flush)
      cnt_d = '0;
    else if (det && (need_m1 > cnt_dec))
      cnt_d = need_m1;
    else
      cnt_d = cnt_dec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  always_comb begin
    bus.stall        = ~bus.flush & (det | (cnt_q != '0));
    bus.stall_cnt    = cnt_q;
    bus.hazard_stage = hazard_stage;
  end

endmodule
